// File: rtl/nibbler_ctrl.sv
// Nibbler fetch/execute sequencer with run/hold handshake and registered decode.
// Optional single-step mode: define NIBBLER_STEP_EN to add the step input.
module nibbler_ctrl #(
  parameter int unsigned IDLE_CYCLES = 2,
  parameter int unsigned CNT_W       = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic       hold,
`ifdef NIBBLER_STEP_EN
  input  logic       step,
`endif
  input  logic [3:0] instr,
  input  logic       c_flag,
  input  logic       z_flag,
  output logic       phase,
  output logic       ir_load,
  output logic       inc_pc,
  output logic       load_pc,
  output logic       load_a,
  output logic       load_flags,
  output logic [2:0] alu_sel,
  output logic       cs_ram,
  output logic       we_ram,
  output logic       oe_alu,
  output logic       oe_in,
  output logic       oe_oprnd,
  output logic       load_out,
  output logic       busy,
  output logic       held
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  typedef struct packed {
    logic       phase;
    logic       ir_load;
    logic       inc_pc;
    logic       load_pc;
    logic       load_a;
    logic       load_flags;
    logic [2:0] alu_sel;
    logic       cs_ram;
    logic       we_ram;
    logic       oe_alu;
    logic       oe_in;
    logic       oe_oprnd;
    logic       load_out;
    logic       busy;
    logic       held;
  } ctl_t;

  localparam logic [CNT_W-1:0] IdleLast = CNT_W'(IDLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctl_t             ctl_q, ctl_d;
  logic             idle_done;
  logic             is_jmp;
  logic             jmp_take;
  logic             two_byte;
  logic             leave_hold;
  logic             stop_after_exec;

`ifdef NIBBLER_STEP_EN
  logic step_q;
  logic step_rise;

  assign step_rise       = step & ~step_q;
  assign leave_hold      = ~hold & step_rise;
  assign stop_after_exec = 1'b1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step;
    end
  end
`else
  assign leave_hold      = ~hold;
  assign stop_after_exec = hold;
`endif

  assign idle_done = (cnt_q == IdleLast);

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      IDLE: begin
        cnt_d = idle_done ? cnt_q : cnt_q + 1'b1;
        if (idle_done && run) state_d = FETCH;
      end
      FETCH: state_d = EXEC;
      EXEC: begin
        if (!run) begin
          state_d = IDLE;
        end else if (stop_after_exec) begin
          state_d = HOLD;
        end else begin
          state_d = FETCH;
        end
      end
      HOLD: begin
        if (leave_hold) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    is_jmp   = 1'b0;
    jmp_take = 1'b0;
    unique case (instr)
      4'b0000: begin is_jmp = 1'b1; jmp_take = c_flag;  end
      4'b0001: begin is_jmp = 1'b1; jmp_take = ~c_flag; end
      4'b1000: begin is_jmp = 1'b1; jmp_take = z_flag;  end
      4'b1001: begin is_jmp = 1'b1; jmp_take = ~z_flag; end
      4'b1100: begin is_jmp = 1'b1; jmp_take = 1'b1;    end
      default: ;
    endcase
  end

  assign two_byte = instr inside {4'b0000, 4'b0001, 4'b0011,
                                  4'b0110, 4'b0111, 4'b1000,
                                  4'b1001, 4'b1011, 4'b1100,
                                  4'b1111};

  // Decode for the state being entered so outputs are flop-driven.
  always_comb begin
    ctl_d = '0;
    unique case (state_d)
      IDLE: ;
      FETCH: begin
        ctl_d.ir_load = 1'b1;
        ctl_d.inc_pc  = 1'b1;
        ctl_d.busy    = 1'b1;
      end
      EXEC: begin
        ctl_d.phase   = 1'b1;
        ctl_d.busy    = 1'b1;
        ctl_d.load_pc = is_jmp & jmp_take;
        ctl_d.inc_pc  = two_byte & ~(is_jmp & jmp_take);
        unique case (instr)
          4'b0010: begin
            ctl_d.oe_oprnd   = 1'b1;
            ctl_d.alu_sel    = 3'b001;
            ctl_d.load_flags = 1'b1;
          end
          4'b0011: begin
            ctl_d.cs_ram     = 1'b1;
            ctl_d.alu_sel    = 3'b001;
            ctl_d.load_flags = 1'b1;
          end
          4'b0100: begin
            ctl_d.oe_oprnd = 1'b1;
            ctl_d.alu_sel  = 3'b010;
            ctl_d.load_a   = 1'b1;
          end
          4'b0101: begin
            ctl_d.oe_in   = 1'b1;
            ctl_d.alu_sel = 3'b010;
            ctl_d.load_a  = 1'b1;
          end
          4'b0110: begin
            ctl_d.cs_ram  = 1'b1;
            ctl_d.alu_sel = 3'b010;
            ctl_d.load_a  = 1'b1;
          end
          4'b0111: begin
            ctl_d.cs_ram  = 1'b1;
            ctl_d.we_ram  = 1'b1;
            ctl_d.oe_alu  = 1'b1;
            ctl_d.alu_sel = 3'b000;
          end
          4'b1010: begin
            ctl_d.oe_oprnd   = 1'b1;
            ctl_d.alu_sel    = 3'b011;
            ctl_d.load_a     = 1'b1;
            ctl_d.load_flags = 1'b1;
          end
          4'b1011: begin
            ctl_d.cs_ram     = 1'b1;
            ctl_d.alu_sel    = 3'b011;
            ctl_d.load_a     = 1'b1;
            ctl_d.load_flags = 1'b1;
          end
          4'b1101: begin
            ctl_d.oe_alu   = 1'b1;
            ctl_d.alu_sel  = 3'b000;
            ctl_d.load_out = 1'b1;
          end
          4'b1110: begin
            ctl_d.oe_oprnd   = 1'b1;
            ctl_d.alu_sel    = 3'b100;
            ctl_d.load_a     = 1'b1;
            ctl_d.load_flags = 1'b1;
          end
          4'b1111: begin
            ctl_d.cs_ram     = 1'b1;
            ctl_d.alu_sel    = 3'b100;
            ctl_d.load_a     = 1'b1;
            ctl_d.load_flags = 1'b1;
          end
          default: ;
        endcase
      end
      HOLD: begin
        ctl_d.phase = 1'b1;
        ctl_d.held  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctl_q   <= ctl_d;
    end
  end

  assign phase      = ctl_q.phase;
  assign ir_load    = ctl_q.ir_load;
  assign inc_pc     = ctl_q.inc_pc;
  assign load_pc    = ctl_q.load_pc;
  assign load_a     = ctl_q.load_a;
  assign load_flags = ctl_q.load_flags;
  assign alu_sel    = ctl_q.alu_sel;
  assign cs_ram     = ctl_q.cs_ram;
  assign we_ram     = ctl_q.we_ram;
  assign oe_alu     = ctl_q.oe_alu;
  assign oe_in      = ctl_q.oe_in;
  assign oe_oprnd   = ctl_q.oe_oprnd;
  assign load_out   = ctl_q.load_out;
  assign busy       = ctl_q.busy;
  assign held       = ctl_q.held;

endmodule

// File: tb/tb_nibbler_ctrl.sv
// Directed bench for nibbler_ctrl (default build).
// Inputs settle before the FETCH->EXEC edge and stay stable through EXEC.
`timescale 1ns/1ps
module tb_nibbler_ctrl;

  logic       clock;
  logic       reset;
  logic       run;
  logic       hold;
`ifdef NIBBLER_STEP_EN
  logic       step;
`endif
  logic [3:0] instr;
  logic       c_flag;
  logic       z_flag;
  logic       phase;
  logic       ir_load;
  logic       inc_pc;
  logic       load_pc;
  logic       load_a;
  logic       load_flags;
  logic [2:0] alu_sel;
  logic       cs_ram;
  logic       we_ram;
  logic       oe_alu;
  logic       oe_in;
  logic       oe_oprnd;
  logic       load_out;
  logic       busy;
  logic       held;

  int errors = 0;
  int checks = 0;

  nibbler_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .run        (run),
    .hold       (hold),
`ifdef NIBBLER_STEP_EN
    .step       (step),
`endif
    .instr      (instr),
    .c_flag     (c_flag),
    .z_flag     (z_flag),
    .phase      (phase),
    .ir_load    (ir_load),
    .inc_pc     (inc_pc),
    .load_pc    (load_pc),
    .load_a     (load_a),
    .load_flags (load_flags),
    .alu_sel    (alu_sel),
    .cs_ram     (cs_ram),
    .we_ram     (we_ram),
    .oe_alu     (oe_alu),
    .oe_in      (oe_in),
    .oe_oprnd   (oe_oprnd),
    .load_out   (load_out),
    .busy       (busy),
    .held       (held)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [16:0] outs;
  assign outs = {phase, ir_load, inc_pc, load_pc, load_a,
                 load_flags, alu_sel, cs_ram, we_ram, oe_alu,
                 oe_in, oe_oprnd, load_out, busy, held};

  function automatic logic [16:0] ev(
    input logic       ph,  input logic irl, input logic inc,
    input logic       lpc, input logic la,  input logic lf,
    input logic [2:0] alu,
    input logic       cs,  input logic we,  input logic oa,
    input logic       oi,  input logic oo,  input logic lo,
    input logic       bz,  input logic hd);
    return {ph, irl, inc, lpc, la, lf, alu, cs, we, oa,
            oi, oo, lo, bz, hd};
  endfunction

  task automatic chk(input string tag,
                     input logic [16:0] obs,
                     input logic [16:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [16:0] ZERO, FET, HLD;
  logic [16:0] JZ_T, JZ_N, ST, ADDI, IN, JC_T, OUT, CMPM, NANDM, LIT;

  initial begin
    ZERO  = '0;
    FET   = ev(0,1,1,0,0,0,3'b000,0,0,0,0,0,0,1,0);
    HLD   = ev(1,0,0,0,0,0,3'b000,0,0,0,0,0,0,0,1);
    JZ_T  = ev(1,0,0,1,0,0,3'b000,0,0,0,0,0,0,1,0);
    JZ_N  = ev(1,0,1,0,0,0,3'b000,0,0,0,0,0,0,1,0);
    ST    = ev(1,0,1,0,0,0,3'b000,1,1,1,0,0,0,1,0);
    ADDI  = ev(1,0,0,0,1,1,3'b011,0,0,0,0,1,0,1,0);
    IN    = ev(1,0,0,0,1,0,3'b010,0,0,0,1,0,0,1,0);
    JC_T  = ev(1,0,0,1,0,0,3'b000,0,0,0,0,0,0,1,0);
    OUT   = ev(1,0,0,0,0,0,3'b000,0,0,1,0,0,1,1,0);
    CMPM  = ev(1,0,1,0,0,1,3'b001,1,0,0,0,0,0,1,0);
    NANDM = ev(1,0,1,0,1,1,3'b100,1,0,0,0,0,0,1,0);
    LIT   = ev(1,0,0,0,1,0,3'b010,0,0,0,0,1,0,1,0);

    reset  = 1'b0;
    run    = 1'b1;
    hold   = 1'b0;
`ifdef NIBBLER_STEP_EN
    step   = 1'b0;
`endif
    instr  = 4'b1000;
    c_flag = 1'b0;
    z_flag = 1'b1;
    #1;
    chk("reset", outs, ZERO);
    reset = 1'b1;

    @(negedge clock); chk("idle", outs, ZERO);
    @(negedge clock); chk("fetch0", outs, FET);
    @(negedge clock); chk("jz_taken", outs, JZ_T);
    z_flag = 1'b0;
    @(negedge clock); chk("fetch1", outs, FET);
    @(negedge clock); chk("jz_not", outs, JZ_N);
    instr = 4'b0111;
    @(negedge clock); chk("fetch2", outs, FET);
    @(negedge clock); chk("st", outs, ST);
    instr = 4'b1010;
    @(negedge clock); chk("fetch3", outs, FET);
    @(negedge clock); chk("addi", outs, ADDI);
    instr = 4'b0101;
    @(negedge clock); chk("fetch4", outs, FET);
    @(negedge clock); chk("in", outs, IN);
    instr  = 4'b0000;
    c_flag = 1'b1;
    @(negedge clock); chk("fetch5", outs, FET);
    @(negedge clock); chk("jc_taken", outs, JC_T);
    instr = 4'b1101;
    @(negedge clock); chk("fetch6", outs, FET);
    @(negedge clock); chk("out", outs, OUT);
    instr = 4'b0011;
    @(negedge clock); chk("fetch7", outs, FET);
    @(negedge clock); chk("cmpm", outs, CMPM);
    instr = 4'b1111;
    @(negedge clock); chk("fetch8", outs, FET);
    @(negedge clock); chk("nandm", outs, NANDM);

    instr = 4'b0100;
    @(negedge clock); chk("fetch9", outs, FET);
    hold = 1'b1;
    @(negedge clock); chk("lit_hold", outs, LIT);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock); chk("held", outs, HLD);
    end
    hold = 1'b0;
    @(negedge clock); chk("resume", outs, FET);
    @(negedge clock); chk("lit", outs, LIT);

    instr = 4'b0101;
    @(negedge clock); chk("fetch10", outs, FET);
    run  = 1'b0;
    hold = 1'b1;
    @(negedge clock); chk("in_stop", outs, IN);
    @(negedge clock); chk("prio_idle", outs, ZERO);
    run  = 1'b1;
    hold = 1'b0;
    @(negedge clock); chk("reidle", outs, ZERO);
    @(negedge clock); chk("restart", outs, FET);

    instr = 4'b0111;
    @(negedge clock); chk("st2", outs, ST);
    #1 reset = 1'b0;
    #1 chk("async_rst", outs, ZERO);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nibbler_ctrl.md
Name: nibbler_ctrl

Overview:
- Control sequencer for the 4-bit Nibbler datapath: PC, program ROM, 12-bit RAM address, accumulator, ALU, flags, input/output latches.
- Generates the fetch/execute `phase` and decodes `instr` with `c_flag`/`z_flag` into per-cycle enables and select lines for the datapath.
- Adds a start/hold handshake so the top level can start, freeze and resume the CPU.
- Replaces the hard-wired decode ROM plus phase flip-flop in `uP`.

Parameters:
- `IDLE_CYCLES`, default 2: cycles spent in IDLE after reset deasserts before `run` is sampled (min 1).
- `CNT_W`, default 2: width of the idle counter (must satisfy 2^CNT_W > IDLE_CYCLES).

Ports:
- `clock` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `run` in 1: level; starts sequencing once IDLE completes.
- `hold` in 1: level; freezes the sequencer at the next phase boundary.
- `instr` in 4: opcode nibble from the IR.
- `c_flag` in 1: carry flag from the flags register.
- `z_flag` in 1: zero flag from the flags register.
- `phase` out 1: 0 = fetch, 1 = execute.
- `ir_load` out 1: load `program_byte` into `instr`/`oprnd`.
- `inc_pc` out 1: PC <= PC+1.
- `load_pc` out 1: PC <= `address_RAM`.
- `load_a` out 1: accumulator load.
- `load_flags` out 1: C/Z update.
- `alu_sel` out 3: ALU op.
- `cs_ram` out 1: RAM chip select.
- `we_ram` out 1: RAM write enable.
- `oe_alu` out 1: ALU drives `data_bus`.
- `oe_in` out 1: pushbuttons drive `data_bus`.
- `oe_oprnd` out 1: operand drives `data_bus`.
- `load_out` out 1: output latch load.
- `busy` out 1: 1 in FETCH/EXEC.
- `held` out 1: 1 in HOLD.

Behaviour:
- Reset (`reset`=0, async):
  - state = IDLE, idle counter = 0.
  - `phase`=0; all enables, `busy` and `held` = 0; `alu_sel`=3'b000.
  - Reset mid-instruction aborts the instruction; there is no partial write, because `we_ram` clears immediately.
- State machine:
  - IDLE: count `IDLE_CYCLES`, then wait for `run`=1; next state FETCH.
  - FETCH (`phase`=0): `ir_load`=1, `inc_pc`=1; next state EXEC.
  - EXEC (`phase`=1): decode as listed below; next state FETCH.
  - `hold`=1 sampled in EXEC: go to HOLD after completing that EXEC.
  - `run`=0 sampled in EXEC: go to IDLE after completing that EXEC.
  - HOLD: all enables 0, `phase` holds 1, `held`=1; `hold`=0 → FETCH.
  - Priority when both are sampled in EXEC: `run`=0 over `hold`=1.
  - `hold` in FETCH is ignored; an instruction never splits.
- Latency:
  - One instruction = 2 cycles.
  - `run` rising → first `ir_load` on the next edge after IDLE completes.
  - `hold` release → FETCH on the next cycle.
- EXEC decode. Two-byte instructions additionally assert `inc_pc` unless a jump is taken:
  - 0000 JC: `load_pc` if C=1.
  - 0001 JNC: `load_pc` if C=0.
  - 1000 JZ: `load_pc` if Z=1.
  - 1001 JNZ: `load_pc` if Z=0.
  - 1100 JMP: `load_pc` always.
  - 0010 CMPI: `oe_oprnd`, `alu_sel`=001, `load_flags`.
  - 0011 CMPM: `cs_ram`, `alu_sel`=001, `load_flags`.
  - 0100 LIT: `oe_oprnd`, `alu_sel`=010, `load_a`.
  - 0101 IN: `oe_in`, `alu_sel`=010, `load_a`.
  - 0110 LD: `cs_ram`, `alu_sel`=010, `load_a`.
  - 0111 ST: `cs_ram`, `we_ram`, `oe_alu`, `alu_sel`=000 (pass A).
  - 1010 ADDI: `oe_oprnd`, `alu_sel`=011, `load_a`, `load_flags`.
  - 1011 ADDM: `cs_ram`, `alu_sel`=011, `load_a`, `load_flags`.
  - 1101 OUT: `oe_alu`, `alu_sel`=000, `load_out`.
  - 1110 NANDI: `oe_oprnd`, `alu_sel`=100, `load_a`, `load_flags`.
  - 1111 NANDM: `cs_ram`, `alu_sel`=100, `load_a`, `load_flags`.
- Two-byte set: 0000, 0001, 0011, 0110, 0111, 1000, 1001, 1011, 1100, 1111.
- Invariants:
  - Never `inc_pc` and `load_pc` together.
  - Never more than one of `oe_alu`, `oe_in`, `oe_oprnd`, `cs_ram`-read.
  - `we_ram` only with `cs_ram`.
- Outputs are registered from the next-state decode: they are valid for the whole cycle their state occupies and glitch-free.
- PC wrap (12-bit 0xFFF→0x000) belongs to the datapath; the controller needs no special handling.

Optional Feature:
- Macro: `NIBBLER_STEP_EN`.
- Defined:
  - Adds input port `step` (1 bit).
  - After every EXEC the FSM enters HOLD; it leaves HOLD only on a rising edge of `step` (edge detected internally, registered) while `hold`=0.
  - This gives one instruction per press.
- Undefined: port absent; HOLD is entered only via `hold`.

Test Plan:
- Reset: `reset`=0 at t=0, released at t=1, `run`=1 → outputs all 0 for `IDLE_CYCLES`; then `phase` toggles 0,1,0,1…; `ir_load`=1 in every fetch.
- Taken jump: `instr`=1000 (JZ), `z_flag`=1 in EXEC → `load_pc`=1, `inc_pc`=0. Same with `z_flag`=0 → `load_pc`=0, `inc_pc`=1.
- Store: `instr`=0111 (ST) → in EXEC `cs_ram`=1, `we_ram`=1, `oe_alu`=1, `alu_sel`=000, `inc_pc`=1; no `load_a`.
- ADDI / IN: `instr`=1010 (ADDI) → `alu_sel`=011, `load_a`=1, `load_flags`=1, `oe_oprnd`=1. `instr`=0101 (IN) → `oe_in`=1, `load_flags`=0.
- Hold mid-run: `hold`=1 asserted during FETCH → current EXEC completes, then HOLD with `held`=1 and enables 0 for 5 cycles; `hold`=0 → FETCH next cycle.
- Async reset in EXEC: `reset`=0 while `instr`=0111 (ST) → `we_ram` drops before the next clock edge; with `NIBBLER_STEP_EN` defined, `step` pulses advance exactly one instruction each.
